// File: rtl/control_pipeline.sv
// Decode-to-writeback control pipeline: carries the decoded control bundle through
// the E, M and W stage registers, stalls E for multi-cycle vector ALU ops, and squashes on flush.
module control_pipeline #(
    parameter int          REG_ADDR_WIDTH      = 4,
    parameter int          MULTI_CYCLE_LAT     = 3,
    parameter logic [2:0]  MULTI_CYCLE_ALUCTRL = 3'b010
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      validD,
    input  logic                      useScalarAluD,
    input  logic                      isScalarOutputD,
    input  logic                      isScalarReg1D,
    input  logic                      isScalarReg2D,
    input  logic                      useInmediateD,
    input  logic [2:0]                aluControlD,
    input  logic                      writeToMemoryEnableD,
    input  logic                      outFlagD,
    input  logic                      resultSelectorD,
    input  logic                      writeEnableScalarD,
    input  logic                      writeEnableVectorD,
    input  logic [REG_ADDR_WIDTH-1:0] rdD,
    input  logic                      flushE,
    output logic                      stallOut,
    output logic                      validE,
    output logic                      useScalarAluE,
    output logic                      isScalarOutputE,
    output logic                      isScalarReg1E,
    output logic                      isScalarReg2E,
    output logic                      useInmediateE,
    output logic [2:0]                aluControlE,
    output logic [REG_ADDR_WIDTH-1:0] rdE,
    output logic                      validM,
    output logic                      writeToMemoryEnableM,
    output logic                      outFlagM,
    output logic                      resultSelectorM,
    output logic                      writeEnableScalarM,
    output logic                      writeEnableVectorM,
    output logic [REG_ADDR_WIDTH-1:0] rdM,
    output logic                      validW,
    output logic                      resultSelectorW,
    output logic                      writeEnableScalarW,
    output logic                      writeEnableVectorW,
    output logic [REG_ADDR_WIDTH-1:0] rdW
);
    localparam int CW = $clog2(MULTI_CYCLE_LAT) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULTI_CYCLE_LAT - 1);

    typedef struct packed {
        logic                      valid;
        logic                      useScalarAlu;
        logic                      isScalarOutput;
        logic                      isScalarReg1;
        logic                      isScalarReg2;
        logic                      useInmediate;
        logic [2:0]                aluControl;
        logic                      writeToMemoryEnable;
        logic                      outFlag;
        logic                      resultSelector;
        logic                      writeEnableScalar;
        logic                      writeEnableVector;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } e_bundle_t;

    typedef struct packed {
        logic                      valid;
        logic                      writeToMemoryEnable;
        logic                      outFlag;
        logic                      resultSelector;
        logic                      writeEnableScalar;
        logic                      writeEnableVector;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } m_bundle_t;

    typedef struct packed {
        logic                      valid;
        logic                      resultSelector;
        logic                      writeEnableScalar;
        logic                      writeEnableVector;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } w_bundle_t;

    e_bundle_t     r_e;
    m_bundle_t     r_m;
    w_bundle_t     r_w;
    logic [CW-1:0] r_cnt;

    e_bundle_t w_d;
    m_bundle_t w_e_to_m;
    logic      w_multi_d;
    logic      w_multi_e;
    logic      w_stall;

    // A non-valid decode slot enters E as an all-zero bubble.
    assign w_d = validD ? '{valid: 1'b1, useScalarAlu: useScalarAluD, isScalarOutput: isScalarOutputD,
                            isScalarReg1: isScalarReg1D, isScalarReg2: isScalarReg2D,
                            useInmediate: useInmediateD, aluControl: aluControlD,
                            writeToMemoryEnable: writeToMemoryEnableD, outFlag: outFlagD,
                            resultSelector: resultSelectorD, writeEnableScalar: writeEnableScalarD,
                            writeEnableVector: writeEnableVectorD, rd: rdD}
                        : '0;

    assign w_e_to_m = '{valid: r_e.valid, writeToMemoryEnable: r_e.writeToMemoryEnable,
                        outFlag: r_e.outFlag, resultSelector: r_e.resultSelector,
                        writeEnableScalar: r_e.writeEnableScalar,
                        writeEnableVector: r_e.writeEnableVector, rd: r_e.rd};

    assign w_multi_d = w_d.valid & ~w_d.useScalarAlu & (w_d.aluControl == MULTI_CYCLE_ALUCTRL);
    assign w_multi_e = r_e.valid & ~r_e.useScalarAlu & (r_e.aluControl == MULTI_CYCLE_ALUCTRL);
    assign w_stall   = w_multi_e & (r_cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_e   <= '0;
            r_m   <= '0;
            r_w   <= '0;
            r_cnt <= '0;
        end else begin
            r_w <= '{valid: r_m.valid, resultSelector: r_m.resultSelector,
                     writeEnableScalar: r_m.writeEnableScalar,
                     writeEnableVector: r_m.writeEnableVector, rd: r_m.rd};
            if (flushE) begin
                r_e   <= '0;
                r_m   <= '0;
                r_cnt <= '0;
            end else if (w_stall) begin
                // E holds its op; M receives a bubble while the count runs down.
                r_m   <= '0;
                r_cnt <= r_cnt - CW'(1);
            end else begin
                r_e   <= w_d;
                r_m   <= w_e_to_m;
                r_cnt <= w_multi_d ? CNT_LOAD : '0;
            end
        end
    end

    assign stallOut             = w_stall;
    assign validE               = r_e.valid;
    assign useScalarAluE        = r_e.useScalarAlu;
    assign isScalarOutputE      = r_e.isScalarOutput;
    assign isScalarReg1E        = r_e.isScalarReg1;
    assign isScalarReg2E        = r_e.isScalarReg2;
    assign useInmediateE        = r_e.useInmediate;
    assign aluControlE          = r_e.aluControl;
    assign rdE                  = r_e.rd;
    assign validM               = r_m.valid;
    assign writeToMemoryEnableM = r_m.writeToMemoryEnable;
    assign outFlagM             = r_m.outFlag;
    assign resultSelectorM      = r_m.resultSelector;
    assign writeEnableScalarM   = r_m.writeEnableScalar;
    assign writeEnableVectorM   = r_m.writeEnableVector;
    assign rdM                  = r_m.rd;
    assign validW               = r_w.valid;
    assign resultSelectorW      = r_w.resultSelector;
    assign writeEnableScalarW   = r_w.writeEnableScalar;
    assign writeEnableVectorW   = r_w.writeEnableVector;
    assign rdW                  = r_w.rd;

endmodule

// File: tb/tb_control_pipeline.sv
// Bench for control_pipeline: a bundle-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_control_pipeline;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    logic validD, useScalarAluD, isScalarOutputD, isScalarReg1D, isScalarReg2D, useInmediateD;
    logic [2:0] aluControlD;
    logic writeToMemoryEnableD, outFlagD, resultSelectorD, writeEnableScalarD, writeEnableVectorD;
    logic [3:0] rdD;
    logic flushE;
    logic stallOut;
    logic validE, useScalarAluE, isScalarOutputE, isScalarReg1E, isScalarReg2E, useInmediateE;
    logic [2:0] aluControlE;
    logic [3:0] rdE;
    logic validM, writeToMemoryEnableM, outFlagM, resultSelectorM, writeEnableScalarM, writeEnableVectorM;
    logic [3:0] rdM;
    logic validW, resultSelectorW, writeEnableScalarW, writeEnableVectorW;
    logic [3:0] rdW;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    control_pipeline #(.REG_ADDR_WIDTH(4), .MULTI_CYCLE_LAT(LAT), .MULTI_CYCLE_ALUCTRL(3'b010)) dut (
        .clk(clk), .rst(rst), .validD(validD), .useScalarAluD(useScalarAluD),
        .isScalarOutputD(isScalarOutputD), .isScalarReg1D(isScalarReg1D), .isScalarReg2D(isScalarReg2D),
        .useInmediateD(useInmediateD), .aluControlD(aluControlD),
        .writeToMemoryEnableD(writeToMemoryEnableD), .outFlagD(outFlagD),
        .resultSelectorD(resultSelectorD), .writeEnableScalarD(writeEnableScalarD),
        .writeEnableVectorD(writeEnableVectorD), .rdD(rdD), .flushE(flushE), .stallOut(stallOut),
        .validE(validE), .useScalarAluE(useScalarAluE), .isScalarOutputE(isScalarOutputE),
        .isScalarReg1E(isScalarReg1E), .isScalarReg2E(isScalarReg2E), .useInmediateE(useInmediateE),
        .aluControlE(aluControlE), .rdE(rdE), .validM(validM),
        .writeToMemoryEnableM(writeToMemoryEnableM), .outFlagM(outFlagM),
        .resultSelectorM(resultSelectorM), .writeEnableScalarM(writeEnableScalarM),
        .writeEnableVectorM(writeEnableVectorM), .rdM(rdM), .validW(validW),
        .resultSelectorW(resultSelectorW), .writeEnableScalarW(writeEnableScalarW),
        .writeEnableVectorW(writeEnableVectorW), .rdW(rdW)
    );

    // Reference model: one whole instruction bundle per stage, plus how long E has held it.
    typedef struct packed {
        logic       valid, usa, iso, isr1, isr2, uim;
        logic [2:0] alu;
        logic       wtm, oflag, rsel, wes, wev;
        logic [3:0] rd;
    } bundle_t;

    bundle_t m_e, m_m, m_w, d_in;
    int      m_age;

    function automatic logic is_multi(input bundle_t b);
        return b.valid && !b.usa && (b.alu == 3'b010);
    endfunction

    function automatic logic model_stall(input bundle_t e, input int age);
        return is_multi(e) && (age < LAT - 1);
    endfunction

    always_comb begin
        d_in = '0;
        if (validD)
            d_in = '{valid: 1'b1, usa: useScalarAluD, iso: isScalarOutputD, isr1: isScalarReg1D,
                     isr2: isScalarReg2D, uim: useInmediateD, alu: aluControlD,
                     wtm: writeToMemoryEnableD, oflag: outFlagD, rsel: resultSelectorD,
                     wes: writeEnableScalarD, wev: writeEnableVectorD, rd: rdD};
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_e <= '0; m_m <= '0; m_w <= '0; m_age <= 0;
        end else if (flushE) begin
            m_e <= '0; m_m <= '0; m_w <= m_m; m_age <= 0;
        end else if (model_stall(m_e, m_age)) begin
            m_m <= '0; m_w <= m_m; m_age <= m_age + 1;
        end else begin
            m_e <= d_in; m_m <= m_e; m_w <= m_m; m_age <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        chk("stallOut", {31'd0, stallOut}, {31'd0, model_stall(m_e, m_age)});
        chk("E_stage",
            {19'd0, validE, useScalarAluE, isScalarOutputE, isScalarReg1E, isScalarReg2E, useInmediateE, aluControlE, rdE},
            {19'd0, m_e.valid, m_e.usa, m_e.iso, m_e.isr1, m_e.isr2, m_e.uim, m_e.alu, m_e.rd});
        chk("M_stage",
            {22'd0, validM, writeToMemoryEnableM, outFlagM, resultSelectorM, writeEnableScalarM, writeEnableVectorM, rdM},
            {22'd0, m_m.valid, m_m.wtm, m_m.oflag, m_m.rsel, m_m.wes, m_m.wev, m_m.rd});
        chk("W_stage",
            {24'd0, validW, resultSelectorW, writeEnableScalarW, writeEnableVectorW, rdW},
            {24'd0, m_w.valid, m_w.rsel, m_w.wes, m_w.wev, m_w.rd});
    end

    task automatic set_d(input logic v, usa, input logic [2:0] alu, input logic wtm, oflag, wes, wev,
                         input logic [3:0] rd);
        validD = v; useScalarAluD = usa; isScalarOutputD = 1'b0; isScalarReg1D = 1'b0;
        isScalarReg2D = 1'b0; useInmediateD = 1'b0; aluControlD = alu;
        writeToMemoryEnableD = wtm; outFlagD = oflag; resultSelectorD = 1'b0;
        writeEnableScalarD = wes; writeEnableVectorD = wev; rdD = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flushE = 1'b0;
        validD = 1'b1; useScalarAluD = 1'b1; isScalarOutputD = 1'b1; isScalarReg1D = 1'b1;
        isScalarReg2D = 1'b1; useInmediateD = 1'b1; aluControlD = 3'b111;
        writeToMemoryEnableD = 1'b1; outFlagD = 1'b1; resultSelectorD = 1'b1;
        writeEnableScalarD = 1'b1; writeEnableVectorD = 1'b1; rdD = 4'hF;

        // Reset with every D input high.
        tick(); tick();
        $display("txn reset: all D inputs high, rst=0");
        chk("rst_validE", {31'd0, validE}, 32'd0);
        chk("rst_rdE", {28'd0, rdE}, 32'd0);
        chk("rst_wtmM", {31'd0, writeToMemoryEnableM}, 32'd0);
        chk("rst_weW", {30'd0, writeEnableScalarW, writeEnableVectorW}, 32'd0);
        chk("rst_stall", {31'd0, stallOut}, 32'd0);
        validD = 1'b0;
        rst = 1'b1;
        tick();
        $display("txn release: validD=0, other D high");
        chk("rel_validE", {31'd0, validE}, 32'd0);
        chk("rel_aluE", {29'd0, aluControlE}, 32'd0);
        chk("rel_stall", {31'd0, stallOut}, 32'd0);

        // Single-cycle scalar op.
        set_d(1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
        tick();
        $display("txn single: alu=1 rd=5");
        chk("sc_aluE", {29'd0, aluControlE}, 32'd1);
        chk("sc_rdE", {28'd0, rdE}, 32'd5);
        set_d(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        chk("sc_weM", {31'd0, writeEnableScalarM}, 32'd1);
        chk("sc_validE", {31'd0, validE}, 32'd0);
        tick();
        chk("sc_weW", {31'd0, writeEnableScalarW}, 32'd1);
        chk("sc_rdW", {28'd0, rdW}, 32'd5);
        chk("model_rdW", {28'd0, m_w.rd}, 32'd5);
        tick();
        chk("sc_bubbleW", {31'd0, validW}, 32'd0);

        // Multi-cycle vector op followed by a single-cycle vector op.
        set_d(1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        tick();
        $display("txn multi: alu=2 rd=7, then alu=1 rd=8");
        chk("mc_stall1", {31'd0, stallOut}, 32'd1);
        chk("mc_rdE1", {28'd0, rdE}, 32'd7);
        set_d(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
        tick();
        chk("mc_stall2", {31'd0, stallOut}, 32'd1);
        chk("mc_validM2", {31'd0, validM}, 32'd0);
        tick();
        chk("mc_stall3", {31'd0, stallOut}, 32'd0);
        chk("mc_rdE3", {28'd0, rdE}, 32'd7);
        chk("mc_validM3", {31'd0, validM}, 32'd0);
        chk("model_stall3", {31'd0, model_stall(m_e, m_age)}, 32'd0);
        tick();
        chk("mc_rdE4", {28'd0, rdE}, 32'd8);
        chk("mc_rdM4", {28'd0, rdM}, 32'd7);
        chk("mc_validM4", {31'd0, validM}, 32'd1);
        set_d(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(); tick();

        // Flush on the first stall cycle with an older op in M.
        set_d(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        tick();
        set_d(1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
        tick();
        $display("txn flush: flushE during first stall cycle");
        chk("fl_stall_pre", {31'd0, stallOut}, 32'd1);
        flushE = 1'b1;
        set_d(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        flushE = 1'b0;
        chk("fl_validE", {31'd0, validE}, 32'd0);
        chk("fl_validM", {31'd0, validM}, 32'd0);
        chk("fl_stall", {31'd0, stallOut}, 32'd0);
        chk("fl_rdW", {28'd0, rdW}, 32'd3);
        chk("fl_validW", {31'd0, validW}, 32'd1);
        tick(); tick();

        // Store then out-flag on consecutive cycles.
        set_d(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        tick();
        $display("txn store/outflag");
        set_d(1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
        tick();
        chk("so_wtmM2", {31'd0, writeToMemoryEnableM}, 32'd1);
        chk("so_ofM2", {31'd0, outFlagM}, 32'd0);
        set_d(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        chk("so_wtmM3", {31'd0, writeToMemoryEnableM}, 32'd0);
        chk("so_ofM3", {31'd0, outFlagM}, 32'd1);
        chk("so_weW3", {30'd0, writeEnableScalarW, writeEnableVectorW}, 32'd0);
        tick();
        chk("so_ofM4", {31'd0, outFlagM}, 32'd0);
        tick();

        // Back-to-back multi-cycle ops: no gap cycle between them.
        set_d(1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        tick();
        $display("txn back-to-back multi: rd=1 then rd=2");
        set_d(1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
        tick(); tick(); tick();
        chk("bb_rdE", {28'd0, rdE}, 32'd2);
        chk("bb_stall", {31'd0, stallOut}, 32'd1);
        chk("bb_rdM", {28'd0, rdM}, 32'd1);
        set_d(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (4) tick();

        // Async reset with E, M and W all valid.
        for (int i = 1; i <= 3; i++) begin
            set_d(1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 4'(i));
            tick();
        end
        $display("txn async reset mid-pipeline");
        chk("ar_full", {29'd0, validE, validM, validW}, 32'd7);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", {29'd0, validE, validM, validW}, 32'd0);
        chk("ar_rdW", {28'd0, rdW}, 32'd0);
        chk("ar_weW", {31'd0, writeEnableScalarW}, 32'd0);
        tick();
        set_d(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        rst = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
